// File: rtl/cpu_step_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_step_ctrl
// Single-step / free-run clock controller for an external CPU. Produces the
// phi0 clock one CPU cycle at a time, captures the data/address buses at the
// end of each cycle and, in single-step mode, hands the data byte to an LCD
// controller through a request/done handshake.
//
// Parameters
//   HALF_PERIOD     clk cycles per phi0 half-phase (1..255)
//   DEBOUNCE_CYCLES stable-high clk cycles to accept a press (1..65535)
//
// Build option
//   STEP_DEBOUNCE_EN  when defined, button presses are debounced; otherwise a
//                     press is the rising edge of the synchronized button.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   step_btn          raw step button (one CPU cycle per press)
//   run_btn           raw run button (toggles free-run mode)
//   ext_db, ext_ab    CPU data / address bus, sampled in CAPTURE
//   lcd_init_done     LCD controller ready
//   lcd_write_done    LCD write complete
//   phi0              CPU clock, idles high
//   lcd_write_start   LCD write request (held until lcd_write_done)
//   lcd_data          captured data byte
//   ab_latch          captured address
//   run_mode          free-run active
//   busy              high whenever the FSM is not IDLE
//   step_count        completed CPU cycles (wraps)
// -----------------------------------------------------------------------------
module cpu_step_ctrl #(
   parameter int HALF_PERIOD     = 4,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        step_btn,
   input  logic        run_btn,
   input  logic [7:0]  ext_db,
   input  logic [15:0] ext_ab,
   input  logic        lcd_init_done,
   input  logic        lcd_write_done,
   output logic        phi0,
   output logic        lcd_write_start,
   output logic [7:0]  lcd_data,
   output logic [15:0] ab_latch,
   output logic        run_mode,
   output logic        busy,
   output logic [15:0] step_count
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_PHI_LO   = 3'd1;
   localparam logic [2:0] S_PHI_HI   = 3'd2;
   localparam logic [2:0] S_CAPTURE  = 3'd3;
   localparam logic [2:0] S_LCD_REQ  = 3'd4;
   localparam logic [2:0] S_LCD_WAIT = 3'd5;

   localparam logic [7:0] HALF_LAST = 8'(HALF_PERIOD - 1);

   // Reject out-of-range parameters at elaboration.
   if (HALF_PERIOD < 1 || HALF_PERIOD > 255 ||
       DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_param
      $error("cpu_step_ctrl: parameter out of range");
   end

   // ---------------- button conditioning (bit 0 = step, bit 1 = run) --------
   logic [1:0] btn_raw_s;
   logic [1:0] sync1_q, sync1_d;
   logic [1:0] sync2_q, sync2_d;
   logic [1:0] press_s;

   assign btn_raw_s = {run_btn, step_btn};

   // Two-flop synchronizer next state.
   always_comb begin
      sync1_d = btn_raw_s;
      sync2_d = sync1_q;
   end

   // Synchronizer flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 2'b00;
         sync2_q <= 2'b00;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

`ifdef STEP_DEBOUNCE_EN
   localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

   logic [1:0][15:0] db_cnt_q, db_cnt_d;
   logic [1:0]       db_fired_q, db_fired_d;

   // Count consecutive high cycles; fire once per press, re-arm on release.
   always_comb begin
      db_cnt_d   = db_cnt_q;
      db_fired_d = db_fired_q;
      press_s    = 2'b00;
      for (int i = 0; i < 2; i++) begin
         if (!sync2_q[i]) begin
            db_cnt_d[i]   = 16'd0;
            db_fired_d[i] = 1'b0;
         end else if (db_fired_q[i]) begin
            db_cnt_d[i] = db_cnt_q[i];
         end else if (db_cnt_q[i] == DB_LAST) begin
            press_s[i]    = 1'b1;
            db_fired_d[i] = 1'b1;
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + 16'd1;
         end
      end
   end

   // Debounce counter flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         db_cnt_q   <= '0;
         db_fired_q <= 2'b00;
      end else begin
         db_cnt_q   <= db_cnt_d;
         db_fired_q <= db_fired_d;
      end
   end
`else
   logic [1:0] prev_q, prev_d;

   // Rising-edge detect on the synchronized buttons.
   always_comb begin
      prev_d  = sync2_q;
      press_s = sync2_q & ~prev_q;
   end

   // Edge-detector history flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= 2'b00;
      end else begin
         prev_q <= prev_d;
      end
   end
`endif

   logic step_pulse_s, run_pulse_s;
   assign step_pulse_s = press_s[0];
   assign run_pulse_s  = press_s[1];

   // ---------------- cycle FSM ----------------------------------------------
   logic [2:0]  state_q, state_d;
   logic [7:0]  half_cnt_q, half_cnt_d;
   logic        free_cycle_q, free_cycle_d;   // current cycle was started by free-run
   logic        run_mode_q, run_mode_d;
   logic        phi0_q, phi0_d;
   logic        lcd_ws_q, lcd_ws_d;
   logic [7:0]  lcd_data_q, lcd_data_d;
   logic [15:0] ab_latch_q, ab_latch_d;
   logic        busy_q, busy_d;
   logic [15:0] step_count_q, step_count_d;

   // Next-state logic. The run toggle takes effect in any state; a run pulse
   // in the same cycle as a step pulse suppresses the step. CAPTURE routes on
   // the mode the cycle was started in, so stopping free-run mid-cycle never
   // produces an LCD write.
   always_comb begin
      state_d      = state_q;
      half_cnt_d   = half_cnt_q;
      free_cycle_d = free_cycle_q;
      run_mode_d   = run_mode_q ^ run_pulse_s;
      lcd_ws_d     = lcd_ws_q;
      lcd_data_d   = lcd_data_q;
      ab_latch_d   = ab_latch_q;
      step_count_d = step_count_q;
      case (state_q)
         S_IDLE: begin
            if (run_mode_d) begin
               state_d      = S_PHI_LO;
               half_cnt_d   = 8'd0;
               free_cycle_d = 1'b1;
            end else if (step_pulse_s && !run_pulse_s && !run_mode_q) begin
               state_d      = S_PHI_LO;
               half_cnt_d   = 8'd0;
               free_cycle_d = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PHI_LO: begin
            if (half_cnt_q == HALF_LAST) begin
               state_d    = S_PHI_HI;
               half_cnt_d = 8'd0;
            end else begin
               half_cnt_d = half_cnt_q + 8'd1;
            end
         end
         S_PHI_HI: begin
            if (half_cnt_q == HALF_LAST) begin
               state_d    = S_CAPTURE;
               half_cnt_d = 8'd0;
            end else begin
               half_cnt_d = half_cnt_q + 8'd1;
            end
         end
         S_CAPTURE: begin
            lcd_data_d   = ext_db;
            ab_latch_d   = ext_ab;
            step_count_d = step_count_q + 16'd1;
            if (free_cycle_q) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_LCD_REQ;
            end
         end
         S_LCD_REQ: begin
            if (lcd_init_done) begin
               lcd_ws_d = 1'b1;
               state_d  = S_LCD_WAIT;
            end else begin
               lcd_ws_d = 1'b0;
            end
         end
         S_LCD_WAIT: begin
            if (lcd_write_done) begin
               lcd_ws_d = 1'b0;
               state_d  = S_IDLE;
            end else begin
               lcd_ws_d = 1'b1;
            end
         end
         default: begin
            state_d  = S_IDLE;
            lcd_ws_d = 1'b0;
         end
      endcase
      // Derived from the next state so the registered copies track state_q.
      phi0_d = (state_d != S_PHI_LO);
      busy_d = (state_d != S_IDLE);
   end

   // FSM and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         half_cnt_q   <= 8'd0;
         free_cycle_q <= 1'b0;
         run_mode_q   <= 1'b0;
         phi0_q       <= 1'b1;
         lcd_ws_q     <= 1'b0;
         lcd_data_q   <= 8'h00;
         ab_latch_q   <= 16'h0000;
         busy_q       <= 1'b0;
         step_count_q <= 16'h0000;
      end else begin
         state_q      <= state_d;
         half_cnt_q   <= half_cnt_d;
         free_cycle_q <= free_cycle_d;
         run_mode_q   <= run_mode_d;
         phi0_q       <= phi0_d;
         lcd_ws_q     <= lcd_ws_d;
         lcd_data_q   <= lcd_data_d;
         ab_latch_q   <= ab_latch_d;
         busy_q       <= busy_d;
         step_count_q <= step_count_d;
      end
   end

   assign phi0            = phi0_q;
   assign lcd_write_start = lcd_ws_q;
   assign lcd_data        = lcd_data_q;
   assign ab_latch        = ab_latch_q;
   assign run_mode        = run_mode_q;
   assign busy            = busy_q;
   assign step_count      = step_count_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Testbench for cpu_step_ctrl (HALF_PERIOD=4, DEBOUNCE_CYCLES=16).
module tb_cpu_step_ctrl;

   localparam int HP = 4;
   localparam int DB = 16;
`ifdef STEP_DEBOUNCE_EN
   localparam int PRESS = DB + 4;
`else
   localparam int PRESS = 2;
`endif

   logic        clk = 1'b0;
   logic        rst, step_btn, run_btn, lcd_init_done, lcd_write_done;
   logic [7:0]  ext_db;
   logic [15:0] ext_ab;
   logic        phi0, lcd_write_start, run_mode, busy;
   logic [7:0]  lcd_data;
   logic [15:0] ab_latch, step_count;

   cpu_step_ctrl #(.HALF_PERIOD(HP), .DEBOUNCE_CYCLES(DB)) dut (
      .clk(clk), .rst(rst), .step_btn(step_btn), .run_btn(run_btn),
      .ext_db(ext_db), .ext_ab(ext_ab),
      .lcd_init_done(lcd_init_done), .lcd_write_done(lcd_write_done),
      .phi0(phi0), .lcd_write_start(lcd_write_start), .lcd_data(lcd_data),
      .ab_latch(ab_latch), .run_mode(run_mode), .busy(busy),
      .step_count(step_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  db;
      logic [15:0] ab;
      int          init_delay;
      int          done_delay;
      bit          extra_press;
      logic [7:0]  exp_lcd;
      logic [15:0] exp_ab;
      int          exp_ws_len;
   } vec_t;

   vec_t vecs[5];

   int checks   = 0;
   int failures = 0;
   logic [15:0] exp_count = 16'h0000;

   // activity monitor, updated once per cycle by tick()
   int cyc, lo_run, lows, bad_lo, bad_spacing, last_fall, rm_rises, rm_falls;
   bit have_fall, ws_seen;
   logic prev_phi, prev_rm;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic mon_clear();
      cyc = 0; lo_run = 0; lows = 0; bad_lo = 0; bad_spacing = 0;
      last_fall = 0; rm_rises = 0; rm_falls = 0; have_fall = 1'b0;
      ws_seen = 1'b0; prev_phi = phi0; prev_rm = run_mode;
   endtask

   // Advance one clock and sample at the falling edge.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (phi0 === 1'b0) begin
         lo_run++;
         if (prev_phi === 1'b1) begin
            lows++;
            // free-run cycle: PHI_LO + PHI_HI + CAPTURE + IDLE
            if (have_fall && (cyc - last_fall) != 2 * HP + 2) bad_spacing++;
            have_fall = 1'b1;
            last_fall = cyc;
         end
      end else begin
         if (prev_phi === 1'b0 && lo_run != HP) bad_lo++;
         lo_run = 0;
      end
      if (lcd_write_start === 1'b1) ws_seen = 1'b1;
      if (run_mode === 1'b1 && prev_rm === 1'b0) rm_rises++;
      if (run_mode === 1'b0 && prev_rm === 1'b1) rm_falls++;
      prev_phi = phi0;
      prev_rm  = run_mode;
   endtask

   // One single-step CPU cycle with LCD handshake.
   task automatic do_vector(input vec_t v, input int idx);
      int n, lo, hi, early, ws_len, idle_busy;
      ext_db = v.db; ext_ab = v.ab;
      lcd_init_done = (v.init_delay == 0); lcd_write_done = 1'b0;
      step_btn = 1'b1;
      n = 0;
      while (phi0 !== 1'b0 && n < PRESS + 40) begin
         if (n == PRESS) step_btn = 1'b0;
         tick(); n++;
      end
      step_btn = 1'b0;
      check($sformatf("v%0d_start", idx), 32'(phi0), 32'd0);
      lo = 0;
      while (phi0 === 1'b0 && lo < 100) begin
         if (v.extra_press) step_btn = (lo < 2);
         tick(); lo++;
      end
      step_btn = 1'b0;
      check($sformatf("v%0d_phi_lo_len", idx), 32'(lo), 32'(HP));
      hi = 0;
      while (step_count === exp_count && hi < 100) begin
         tick(); hi++;
      end
      check($sformatf("v%0d_phi_hi_plus_capture", idx), 32'(hi), 32'(HP + 1));
      exp_count = exp_count + 16'd1;
      check($sformatf("v%0d_step_count", idx), 32'(step_count), 32'(exp_count));
      check($sformatf("v%0d_lcd_data", idx), 32'(lcd_data), 32'(v.exp_lcd));
      check($sformatf("v%0d_ab_latch", idx), 32'(ab_latch), 32'(v.exp_ab));
      early = 0;
      for (int i = 0; i < v.init_delay; i++) begin
         if (lcd_write_start !== 1'b0 || busy !== 1'b1) early++;
         tick();
      end
      check($sformatf("v%0d_req_held_before_init", idx), 32'(early), 32'd0);
      lcd_init_done = 1'b1;
      tick();
      check($sformatf("v%0d_ws_after_init", idx), 32'(lcd_write_start), 32'd1);
      ws_len = 1;
      while (lcd_write_start === 1'b1 && ws_len < 200) begin
         if (ws_len >= v.done_delay) lcd_write_done = 1'b1;
         tick();
         if (lcd_write_start === 1'b1) ws_len++;
      end
      lcd_write_done = 1'b0;
      check($sformatf("v%0d_ws_len", idx), 32'(ws_len), 32'(v.exp_ws_len));
      check($sformatf("v%0d_idle_busy", idx), 32'(busy), 32'd0);
      check($sformatf("v%0d_idle_phi0", idx), 32'(phi0), 32'd1);
      if (v.extra_press) begin
         idle_busy = 0;
         repeat (20) begin
            tick();
            if (busy !== 1'b0) idle_busy++;
         end
         check($sformatf("v%0d_busy_press_discarded", idx), 32'(idle_busy), 32'd0);
         check($sformatf("v%0d_count_after_discard", idx), 32'(step_count), 32'(exp_count));
      end
   endtask

   // Start free-run (optionally with a simultaneous step press), stop it after gap.
   task automatic free_run(input int gap, input bit with_step, input string tag);
      int n;
      logic [15:0] base;
      lcd_init_done = 1'b1; lcd_write_done = 1'b0;
      base = exp_count;
      mon_clear();
      run_btn = 1'b1; step_btn = with_step;
      repeat (PRESS) tick();
      run_btn = 1'b0; step_btn = 1'b0;
      repeat (gap) tick();
      run_btn = 1'b1;
      repeat (PRESS) tick();
      run_btn = 1'b0;
      n = 0;
      while ((busy !== 1'b0 || run_mode !== 1'b0) && n < 300) begin
         tick(); n++;
      end
      check({tag, "_stop_timeout"}, 32'(n < 300), 32'd1);
      repeat (10) tick();
      check({tag, "_cycles_ran"}, 32'(lows > 0), 32'd1);
      check({tag, "_low_width"}, 32'(bad_lo), 32'd0);
      check({tag, "_period"}, 32'(bad_spacing), 32'd0);
      check({tag, "_no_lcd_write"}, 32'(ws_seen), 32'd0);
      check({tag, "_run_rises"}, 32'(rm_rises), 32'd1);
      check({tag, "_run_falls"}, 32'(rm_falls), 32'd1);
      exp_count = base + 16'(lows);
      check({tag, "_step_count"}, 32'(step_count), 32'(exp_count));
      check({tag, "_phi0_idle"}, 32'(phi0), 32'd1);
      check({tag, "_busy_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_phi0"}, 32'(phi0), 32'd1);
      check({tag, "_ws"}, 32'(lcd_write_start), 32'd0);
      check({tag, "_count"}, 32'(step_count), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_run_mode"}, 32'(run_mode), 32'd0);
      check({tag, "_lcd_data"}, 32'(lcd_data), 32'd0);
      check({tag, "_ab_latch"}, 32'(ab_latch), 32'd0);
   endtask

   // Watchdog: the bench must always end by itself.
   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      //          db     ab        init done extra exp_lcd exp_ab   ws_len
      vecs[0] = '{8'hA9, 16'h0200, 0,   3,   1'b0, 8'hA9, 16'h0200, 3};
      vecs[1] = '{8'h00, 16'hFFFF, 0,   1,   1'b0, 8'h00, 16'hFFFF, 1};
      vecs[2] = '{8'hFF, 16'h0000, 50,  2,   1'b0, 8'hFF, 16'h0000, 2};
      vecs[3] = '{8'h5A, 16'h1234, 1,   5,   1'b1, 8'h5A, 16'h1234, 5};
      vecs[4] = '{8'h3C, 16'h8001, 0,   3,   1'b1, 8'h3C, 16'h8001, 3};

      rst = 1'b1; step_btn = 1'b0; run_btn = 1'b0;
      ext_db = 8'h00; ext_ab = 16'h0000;
      lcd_init_done = 1'b0; lcd_write_done = 1'b0;
      mon_clear();
      repeat (3) tick();
      check_reset_state("reset");
      rst = 1'b0;
      repeat (2) tick();

      for (int i = 0; i < 5; i++) begin
         do_vector(vecs[i], i);
         repeat (3) tick();
      end

      free_run(10, 1'b0, "run_gap10");
      free_run(30, 1'b0, "run_gap30");
      free_run(10, 1'b1, "step_and_run");

      // Reset during PHI_LO.
      lcd_init_done = 1'b1;
      step_btn = 1'b1;
      n = 0;
      while (phi0 !== 1'b0 && n < PRESS + 40) begin
         if (n == PRESS) step_btn = 1'b0;
         tick(); n++;
      end
      step_btn = 1'b0;
      check("rst_lo_reached", 32'(phi0), 32'd0);
      tick();
      rst = 1'b1;
      tick();
      check_reset_state("rst_phi_lo");
      rst = 1'b0;
      exp_count = 16'h0000;
      repeat (3) tick();

      // Reset during LCD_WAIT.
      ext_db = 8'h77; ext_ab = 16'h4242; lcd_write_done = 1'b0;
      step_btn = 1'b1;
      n = 0;
      while (lcd_write_start !== 1'b1 && n < PRESS + 80) begin
         if (n == PRESS) step_btn = 1'b0;
         tick(); n++;
      end
      step_btn = 1'b0;
      check("rst_wait_reached", 32'(lcd_write_start), 32'd1);
      tick();
      rst = 1'b1;
      tick();
      check_reset_state("rst_lcd_wait");
      rst = 1'b0;
      exp_count = 16'h0000;
      repeat (3) tick();

      // Normal operation resumes from a clean count.
      do_vector(vecs[0], 10);

`ifdef STEP_DEBOUNCE_EN
      // A 10-cycle glitch is shorter than the debounce window.
      mon_clear();
      step_btn = 1'b1;
      repeat (10) tick();
      step_btn = 1'b0;
      n = 0;
      repeat (40) begin
         tick();
         if (busy !== 1'b0) n++;
      end
      check("db_glitch_ignored", 32'(n), 32'd0);
      // A 20-cycle press yields exactly one CPU cycle.
      lcd_init_done = 1'b1; lcd_write_done = 1'b1;
      mon_clear();
      step_btn = 1'b1;
      repeat (20) tick();
      step_btn = 1'b0;
      repeat (60) tick();
      lcd_write_done = 1'b0;
      check("db_one_step", 32'(lows), 32'd1);
      exp_count = exp_count + 16'd1;
      check("db_step_count", 32'(step_count), 32'(exp_count));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
